core_run_ctl: RTL and testbench
===============================

# core_run_ctl

Run/halt/step controller that sequences the core from an external debug or host command port. It owns the core's clock-enable and synchronous core reset, counts single steps, and stops the core on an optional PC breakpoint. It sits between the host interface and the core top level, and observes the core's PC output.

## Interface
Parameters:
- PC_W, default `PC_LEN, width of the core PC and of CMD_ARG.
- RST_CYC, default 4, number of cycles CORE_RSTN is held low per core-reset command (≥1).

Ports:
- CLK  in  1  system clock; the core uses the same clock.
- RSTN  in  1  asynchronous, active-low reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  command accepted when CMD_VALID & CMD_READY at a rising CLK.
- CMD_OP  in  3  0 NOP, 1 RUN, 2 HALT, 3 STEP, 4 SET_BP, 5 CLR_BP, 6 CORE_RESET, 7 reserved (treated as NOP).
- CMD_ARG  in  PC_W  step count (STEP) or breakpoint PC (SET_BP).
- CORE_PC  in  PC_W  core's current PC.
- CORE_EN  out  1  core clock-enable; the core advances one instruction per CLK while high.
- CORE_RSTN  out  1  synchronous active-low reset to the core.
- HALTED  out  1  high in HALT.
- BP_HIT  out  1  sticky; set on a breakpoint stop, cleared by the next accepted RUN/STEP/CORE_RESET.
- STATE  out  2  0 RST_HOLD, 1 HALT, 2 RUN, 3 STEP.

## Operation
- FSM states are RST_HOLD, HALT, RUN and STEP.
- RSTN low forces the following, all asynchronously: state RST_HOLD, reset counter = RST_CYC-1, CORE_RSTN=0, CORE_EN=0, BP_HIT=0, breakpoint invalid, step counter 0, skip flag 0.
- RST_HOLD:
  - CORE_RSTN=0 and CMD_READY=0.
  - The counter decrements each cycle. At 0 the next state is HALT.
- HALT:
  - CMD_READY=1.
  - RUN sets the skip flag and goes to RUN.
  - STEP loads the counter with CMD_ARG (0 treated as 1) and goes to STEP.
  - SET_BP/CLR_BP update the breakpoint register and stay in HALT.
  - CORE_RESET reloads the counter and goes to RST_HOLD.
  - HALT and NOP are no-ops.
- RUN:
  - CMD_READY=1. Only HALT, CORE_RESET, SET_BP and CLR_BP take effect; RUN and STEP are accepted and ignored.
  - Breakpoint match condition: bp_valid & CORE_PC==bp & !skip, evaluated combinationally. On a match, CORE_EN is 0 that cycle, the next state is HALT and BP_HIT is set. The instruction at the breakpoint PC is not executed.
  - The skip flag clears after the first cycle with CORE_EN=1, so resuming from a breakpoint executes the breakpoint instruction once.
- STEP:
  - CMD_READY=0, CORE_EN=1. The counter decrements each cycle; the state returns to HALT after the cycle where the counter equals 1.
  - A breakpoint is not checked on the first step cycle. A match on later cycles ends STEP early with BP_HIT set.
- CORE_EN = (RUN & !match) | STEP. It is 0 in HALT and RST_HOLD.
- Simultaneous events in RUN: a HALT command and a breakpoint match in the same cycle go to HALT with BP_HIT set. A CORE_RESET command overrides a breakpoint match and goes to RST_HOLD; BP_HIT stays cleared.
- PC compare is full PC_W-bit equality. The step counter is PC_W bits wide, with a maximum of 2^PC_W-1 steps.

## Timing
- Reset values: CMD_READY=0, CORE_EN=0, CORE_RSTN=0, HALTED=0, BP_HIT=0, STATE=0.
- After RSTN rises, CORE_RSTN is low for exactly RST_CYC CLK edges. HALTED rises in the cycle after that.
- RUN accepted at edge N: STATE=RUN and CORE_EN=1 from cycle N+1.
- HALT accepted at edge N: CORE_EN=0 from cycle N+1. The core executes no instruction after edge N+1.
- STEP n accepted at edge N: CORE_EN=1 for exactly n cycles (N+1 … N+n), and HALTED=1 at N+n+1.
- State is registered. CORE_EN is combinational from the state, CORE_PC and the breakpoint register. There is zero latency from a CORE_PC match to CORE_EN=0.

## Configuration
- Macro: CORE_RUN_CTL_BP_EN.
- Defined: breakpoint register, skip flag, match logic and BP_HIT are present as described above.
- Undefined:
  - SET_BP and CLR_BP are accepted as no-ops.
  - BP_HIT is tied to 0 and the match term is constant 0.
  - All other behaviour is unchanged.

## Test plan
- Release RSTN with RST_CYC=4 → CORE_RSTN low for 4 edges, then HALTED=1, STATE=1, CMD_READY=1, CORE_EN=0.
- STEP with arg 3 from HALT → CORE_EN high for exactly 3 cycles, CMD_READY=0 throughout, then HALTED=1. STEP with arg 0 → exactly 1 cycle.
- SET_BP 0x05, RUN, with the core PC counting 0,1,2,… → CORE_EN=0 in the cycle CORE_PC=5, then HALT with BP_HIT=1. A following RUN executes PC 5 (skip) and BP_HIT clears.
- RUN, then HALT at cycle 10 → CORE_EN falls the cycle after acceptance. Repeated HALT in HALT has no effect.
- CORE_RESET issued while in RUN → RST_HOLD with CORE_RSTN low for RST_CYC cycles, then HALT. RSTN asserted mid-STEP → all outputs immediately at reset values.
- With the macro undefined: SET_BP 0x02 then RUN → the core runs through PC 2 and BP_HIT stays 0.

Source files
------------

// File: rtl/core_run_ctl.sv
// Run/halt/step sequencer for the core: owns core clock-enable and core reset.
// Optional PC breakpoint logic is compiled in when CORE_RUN_CTL_BP_EN is defined.
`ifndef PC_LEN
`define PC_LEN 16
`endif

module core_run_ctl #(
  parameter int PC_W    = `PC_LEN,
  parameter int RST_CYC = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      cmd_op,
  input  logic [PC_W-1:0] cmd_arg,
  input  logic [PC_W-1:0] core_pc,
  output logic            core_en,
  output logic            core_rstn,
  output logic            halted,
  output logic            bp_hit,
  output logic [1:0]      state
);

  localparam int RST_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RST_CYC - 1);
  localparam logic [RST_W-1:0] RST_ONE  = RST_W'(1);
  localparam logic [PC_W-1:0]  PC_ONE   = PC_W'(1);

  localparam logic [2:0] OP_RUN    = 3'd1;
  localparam logic [2:0] OP_HALT   = 3'd2;
  localparam logic [2:0] OP_STEP   = 3'd3;
  localparam logic [2:0] OP_SET_BP = 3'd4;
  localparam logic [2:0] OP_CLR_BP = 3'd5;
  localparam logic [2:0] OP_CRESET = 3'd6;

  typedef enum logic [1:0] {
    ST_RST_HOLD = 2'd0,
    ST_HALT     = 2'd1,
    ST_RUN      = 2'd2,
    ST_STEP     = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [RST_W-1:0]  rst_cnt_reg, rst_cnt_next;
  logic [PC_W-1:0]   step_cnt_reg, step_cnt_next;
  logic              accept;
  logic              match;
  logic              bp_set, bp_clr, hit_set, hit_clr, skip_set;

  assign cmd_ready = (state_reg == ST_HALT) || (state_reg == ST_RUN);
  assign accept    = cmd_valid && cmd_ready;
  // A breakpoint match gates the enable in the same cycle, so the bp instruction never retires.
  assign core_en   = ((state_reg == ST_RUN) && !match) || (state_reg == ST_STEP);
  assign core_rstn = (state_reg != ST_RST_HOLD);
  assign halted    = (state_reg == ST_HALT);
  assign state     = state_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg    <= ST_RST_HOLD;
      rst_cnt_reg  <= RST_LOAD;
      step_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      rst_cnt_reg  <= rst_cnt_next;
      step_cnt_reg <= step_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    rst_cnt_next  = rst_cnt_reg;
    step_cnt_next = step_cnt_reg;
    bp_set        = 1'b0;
    bp_clr        = 1'b0;
    hit_set       = 1'b0;
    hit_clr       = 1'b0;
    skip_set      = 1'b0;
    case (state_reg)
      ST_RST_HOLD: begin
        if (rst_cnt_reg == '0) state_next = ST_HALT;
        else                   rst_cnt_next = rst_cnt_reg - RST_ONE;
      end
      ST_HALT: begin
        if (accept) begin
          case (cmd_op)
            OP_RUN: begin
              state_next = ST_RUN;
              skip_set   = 1'b1;
              hit_clr    = 1'b1;
            end
            OP_STEP: begin
              step_cnt_next = (cmd_arg == '0) ? PC_ONE : cmd_arg;
              state_next    = ST_STEP;
              skip_set      = 1'b1;
              hit_clr       = 1'b1;
            end
            OP_SET_BP: bp_set = 1'b1;
            OP_CLR_BP: bp_clr = 1'b1;
            OP_CRESET: begin
              rst_cnt_next = RST_LOAD;
              state_next   = ST_RST_HOLD;
              hit_clr      = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (accept && (cmd_op == OP_RUN || cmd_op == OP_STEP)) hit_clr = 1'b1;
        if (accept && cmd_op == OP_SET_BP) bp_set = 1'b1;
        if (accept && cmd_op == OP_CLR_BP) bp_clr = 1'b1;
        // Core reset outranks a breakpoint hit; a HALT racing a hit still reports the hit.
        if (accept && cmd_op == OP_CRESET) begin
          rst_cnt_next = RST_LOAD;
          state_next   = ST_RST_HOLD;
          hit_clr      = 1'b1;
        end else if (match) begin
          state_next = ST_HALT;
          hit_set    = 1'b1;
        end else if (accept && cmd_op == OP_HALT) begin
          state_next = ST_HALT;
        end
      end
      ST_STEP: begin
        step_cnt_next = step_cnt_reg - PC_ONE;
        if (match) hit_set = 1'b1;
        if (step_cnt_reg == PC_ONE || match) state_next = ST_HALT;
      end
      default: state_next = ST_RST_HOLD;
    endcase
  end

`ifdef CORE_RUN_CTL_BP_EN
  logic [PC_W-1:0] bp_reg;
  logic            bp_valid_reg;
  logic            skip_reg;
  logic            bp_hit_reg;

  // skip masks the first enabled cycle after RUN/STEP so a resume can leave the bp PC.
  assign match  = bp_valid_reg && (core_pc == bp_reg) && !skip_reg &&
                  ((state_reg == ST_RUN) || (state_reg == ST_STEP));
  assign bp_hit = bp_hit_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bp_reg       <= '0;
      bp_valid_reg <= 1'b0;
      skip_reg     <= 1'b0;
      bp_hit_reg   <= 1'b0;
    end else begin
      if (bp_set) begin
        bp_reg       <= cmd_arg;
        bp_valid_reg <= 1'b1;
      end else if (bp_clr) begin
        bp_valid_reg <= 1'b0;
      end
      if (skip_set)     skip_reg <= 1'b1;
      else if (core_en) skip_reg <= 1'b0;
      if (hit_set)      bp_hit_reg <= 1'b1;
      else if (hit_clr) bp_hit_reg <= 1'b0;
    end
  end
`else
  logic unused_bp;
  assign match     = 1'b0;
  assign bp_hit    = 1'b0;
  assign unused_bp = ^{core_pc, bp_set, bp_clr, hit_set, hit_clr, skip_set};
`endif

endmodule

// File: tb/tb_core_run_ctl.sv
// Bench for core_run_ctl: directed scenarios then random commands, checked each
// cycle against a rule-level model; the bench also plays the core's PC counter.
module tb_core_run_ctl;
  localparam int PC_W    = 8;
  localparam int RST_CYC = 4;
`ifdef CORE_RUN_CTL_BP_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [2:0]      cmd_op = 3'd0;
  logic [PC_W-1:0] cmd_arg = '0;
  logic [PC_W-1:0] core_pc = '0;
  logic            core_en, core_rstn, halted, bp_hit;
  logic [1:0]      state;

  core_run_ctl #(.PC_W(PC_W), .RST_CYC(RST_CYC)) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .core_pc(core_pc), .core_en(core_en),
    .core_rstn(core_rstn), .halted(halted), .bp_hit(bp_hit), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: mode code (0 hold,1 halt,2 run,3 step), cycles spent in hold,
  // steps remaining, breakpoint, "enabled since last resume", sticky hit.
  int m_state, m_hold, m_steps, m_bp, pc;
  bit m_bpv, m_armed, m_hit;
  int en_cnt, rst_lo_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_hold = 0; m_steps = 0; m_bp = 0;
    m_bpv = 0; m_armed = 1; m_hit = 0;
  endtask

  task automatic tick();
    bit mt, e_en, e_ready, e_rstn, acc;
    int op, arg, ns;
    #1;
    mt      = BP && m_bpv && (pc == m_bp) && m_armed && (m_state == 2 || m_state == 3);
    e_en    = rstn && ((m_state == 2 && !mt) || m_state == 3);
    e_ready = rstn && (m_state == 1 || m_state == 2);
    e_rstn  = rstn && (m_state != 0);
    chk("state", 32'(state), rstn ? 32'(m_state) : 32'd0);
    chk("core_en", 32'(core_en), 32'(e_en));
    chk("cmd_ready", 32'(cmd_ready), 32'(e_ready));
    chk("core_rstn", 32'(core_rstn), 32'(e_rstn));
    chk("halted", 32'(halted), 32'(rstn && m_state == 1));
    chk("bp_hit", 32'(bp_hit), 32'(m_hit));
    if (core_en === 1'b1) en_cnt++;
    if (core_rstn === 1'b0) rst_lo_cnt++;
    acc = cmd_valid && e_ready;
    op  = int'(cmd_op);
    arg = int'(cmd_arg);
    @(posedge clk);
    if (rstn) begin
      ns = m_state;
      if (e_en) m_armed = 1;
      case (m_state)
        0: begin
          m_hold++;
          if (m_hold == RST_CYC) ns = 1;
        end
        1: if (acc) begin
          case (op)
            1: begin ns = 2; m_armed = 0; m_hit = 0; end
            3: begin m_steps = (arg == 0) ? 1 : arg; ns = 3; m_armed = 0; m_hit = 0; end
            4: if (BP) begin m_bp = arg; m_bpv = 1; end
            5: if (BP) m_bpv = 0;
            6: begin ns = 0; m_hold = 0; m_hit = 0; end
            default: ;
          endcase
        end
        2: begin
          if (acc && (op == 1 || op == 3)) m_hit = 0;
          if (acc && op == 4 && BP) begin m_bp = arg; m_bpv = 1; end
          if (acc && op == 5 && BP) m_bpv = 0;
          if (acc && op == 6) begin ns = 0; m_hold = 0; m_hit = 0; end
          else if (mt) begin ns = 1; m_hit = 1; end
          else if (acc && op == 2) ns = 1;
        end
        default: begin
          m_steps--;
          if (mt) m_hit = 1;
          if (m_steps == 0 || mt) ns = 1;
        end
      endcase
      m_state = ns;
    end
    if (!e_rstn) pc = 0;
    else if (e_en) pc = (pc + 1) % (1 << PC_W);
    @(negedge clk);
    core_pc = PC_W'(pc);
  endtask

  task automatic issue(input int op, input int arg);
    cmd_valid = 1'b1;
    cmd_op    = 3'(op);
    cmd_arg   = PC_W'(arg);
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
  endtask

  task automatic async_reset();
    rstn = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_core_en", 32'(core_en), 32'd0);
    chk("arst_core_rstn", 32'(core_rstn), 32'd0);
    chk("arst_ready", 32'(cmd_ready), 32'd0);
    chk("arst_halted", 32'(halted), 32'd0);
    chk("arst_bp_hit", 32'(bp_hit), 32'd0);
    model_reset();
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    int r;
    pc = 0;
    en_cnt = 0;
    model_reset();
    tick();
    tick();
    rstn = 1'b1;

    // Reset release: hold length then HALT
    rst_lo_cnt = 0;
    repeat (6) tick();
    chk("rst_hold_len", 32'(rst_lo_cnt), 32'd4);

    // STEP 3 and STEP 0
    en_cnt = 0;
    issue(3, 3);
    repeat (5) tick();
    chk("step3_en_cycles", 32'(en_cnt), 32'd3);
    en_cnt = 0;
    issue(3, 0);
    repeat (3) tick();
    chk("step0_en_cycles", 32'(en_cnt), 32'd1);

    // Restart the core so its PC counts from 0
    issue(6, 0);
    repeat (6) tick();
`ifdef CORE_RUN_CTL_BP_EN
    issue(4, 5);
    issue(1, 0);
    en_cnt = 0;
    repeat (8) tick();
    chk("bp_en_cycles", 32'(en_cnt), 32'd5);
    chk("bp_hit_set", 32'(bp_hit), 32'd1);
    en_cnt = 0;
    issue(1, 0);
    repeat (3) tick();
    chk("bp_resume_en", 32'(en_cnt), 32'd3);
    chk("bp_hit_cleared", 32'(bp_hit), 32'd0);
    issue(2, 0);
    issue(5, 0);
`else
    issue(4, 2);
    issue(1, 0);
    en_cnt = 0;
    repeat (5) tick();
    chk("nobp_en_cycles", 32'(en_cnt), 32'd5);
    chk("nobp_hit", 32'(bp_hit), 32'd0);
    issue(2, 0);
`endif
    tick();

    // RUN then HALT; repeated HALT is a no-op
    issue(1, 0);
    repeat (10) tick();
    issue(2, 0);
    en_cnt = 0;
    repeat (3) tick();
    chk("halt_en_cycles", 32'(en_cnt), 32'd0);
    issue(2, 0);
    chk("halt_again", 32'(halted), 32'd1);

    // CORE_RESET while running
    issue(1, 0);
    repeat (2) tick();
    issue(6, 0);
    rst_lo_cnt = 0;
    repeat (6) tick();
    chk("creset_hold_len", 32'(rst_lo_cnt), 32'd4);

    // Asynchronous reset mid-STEP
    issue(3, 5);
    repeat (2) tick();
    async_reset();
    repeat (6) tick();

    // Random commands against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        async_reset();
      end else begin
        cmd_valid = ($urandom_range(0, 2) == 0);
        r = $urandom_range(0, 9);
        case (r)
          0, 1: cmd_op = 3'd1;
          2, 3: cmd_op = 3'd2;
          4: begin cmd_op = 3'd3; cmd_arg = PC_W'($urandom_range(0, 5)); end
          5: begin cmd_op = 3'd4; cmd_arg = PC_W'(pc + $urandom_range(0, 12)); end
          6: cmd_op = 3'd5;
          7: cmd_op = ($urandom_range(0, 3) == 0) ? 3'd6 : 3'd0;
          8: cmd_op = 3'd0;
          default: cmd_op = 3'd7;
        endcase
        tick();
      end
    end
    cmd_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
